// File: rtl/fetch_unit_if.sv
// IF-stage bus: instruction memory port plus the bundle handed to the IF/ID register.
// master = fetch unit, slave = memory / IF-ID side.
interface fetch_unit_if #(
    parameter int NB_INSTR = 32,
    parameter int NB_PC    = 32
);
    logic [NB_PC-1:0]    o_imem_addr;
    logic [NB_INSTR-1:0] i_imem_data;
    logic [NB_INSTR-1:0] o_instr;
    logic [NB_PC-1:0]    o_pc;
    logic [NB_PC-1:0]    o_pc_next;
    logic                o_valid;
    logic                o_flush;

    modport master (
        output o_imem_addr,
        input  i_imem_data,
        output o_instr,
        output o_pc,
        output o_pc_next,
        output o_valid,
        output o_flush
    );

    modport slave (
        input  o_imem_addr,
        output i_imem_data,
        input  o_instr,
        input  o_pc,
        input  o_pc_next,
        input  o_valid,
        input  o_flush
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives the 1-cycle synchronous instruction memory,
// presents instr/pc/pc+4 to IF/ID, handles branch redirect, stall, halt, single-step.
module fetch_unit #(
    parameter int                   NB_INSTR   = 32,
    parameter int                   NB_PC      = 32,
    parameter logic [NB_PC-1:0]     RESET_PC   = '0,
    parameter logic [NB_INSTR-1:0]  HALT_INSTR = '1,
    parameter logic [NB_INSTR-1:0]  NOP_INSTR  = NB_INSTR'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic             i_stall,
    input  logic             i_branch,
    input  logic [NB_PC-1:0] i_branch_target,
    fetch_unit_if.master     bus,
    output logic             o_halted,
    output logic             o_idle
);
    typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_e;

    localparam logic [NB_PC-1:0] FOUR  = NB_PC'(4);
    localparam logic [NB_PC-1:0] ALIGN = ~NB_PC'(3);

    state_e           state_q;
    logic             halted_q;
    logic             idle_q;
    logic [NB_PC-1:0] pc_q;
    logic [NB_PC-1:0] pc_d;
    logic [NB_PC-1:0] req_pc_q;
    logic [NB_PC-1:0] req_pc_d;
    logic             req_valid_q;
    logic             req_valid_d;

    logic [NB_PC-1:0] addr;
    logic [NB_PC-1:0] tgt;
    logic             valid;
    logic             flush;
    logic             active;
    logic             fe;
    logic             halt_det;
    logic             go_halt;

    assign active   = (state_q == RUN) || (state_q == STEP);
    assign fe       = (state_q == RUN) || ((state_q == STEP) && i_step);
    assign halt_det = req_valid_q && (bus.i_imem_data == HALT_INSTR);
    assign tgt      = i_branch_target & ALIGN;

    // Branch beats stall beats halt-detect beats fetch.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        addr        = pc_q;
        valid       = 1'b0;
        flush       = 1'b0;
        go_halt     = 1'b0;
        priority case (1'b1)
            !active: begin
                if (i_start) begin
                    pc_d        = RESET_PC;
                    req_pc_d    = RESET_PC;
                    req_valid_d = 1'b0;
                end
            end
            i_branch: begin
                addr        = tgt;
                req_pc_d    = tgt;
                pc_d        = tgt + FOUR;
                req_valid_d = 1'b1;
                flush       = 1'b1;
            end
            i_stall: begin
                addr  = req_pc_q;
                valid = req_valid_q;
            end
            halt_det: begin
                go_halt     = 1'b1;
                req_valid_d = 1'b0;
            end
            fe: begin
                req_pc_d    = pc_q;
                pc_d        = pc_q + FOUR;
                req_valid_d = 1'b1;
                valid       = req_valid_q;
            end
            default: begin
                req_pc_d    = pc_q;
                req_valid_d = 1'b0;
                valid       = req_valid_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            halted_q    <= 1'b0;
            idle_q      <= 1'b1;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            unique case (state_q)
                IDLE, HALT: begin
                    if (i_start) begin
                        state_q  <= i_step_mode ? STEP : RUN;
                        halted_q <= 1'b0;
                        idle_q   <= 1'b0;
                    end
                end
                RUN, STEP: begin
                    if (go_halt) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_imem_addr = addr;
    assign bus.o_valid     = valid;
    assign bus.o_flush     = flush;
    assign bus.o_instr     = valid ? bus.i_imem_data : NOP_INSTR;
    assign bus.o_pc        = req_pc_q;
    assign bus.o_pc_next   = req_pc_q + FOUR;
    assign o_halted        = halted_q;
    assign o_idle          = idle_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle reference model of the fetch rules plus
// directed literal expectations queued from the stimulus thread.
module tb_fetch_unit;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
    localparam int F_ADDR = 0, F_INSTR = 1, F_PC = 2, F_NXT = 3;
    localparam int F_V = 4, F_FL = 5, F_H = 6, F_I = 7;

    logic        clk = 1'b0;
    logic        rst, start, step_mode, step, stall, branch;
    logic [31:0] target;
    logic        halted, idle;
    logic [31:0] mem [256];

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        int          fld;
        logic [31:0] exp;
    } pin_t;
    pin_t pins[$];

    int          m_mode;
    logic [31:0] m_pc, m_req;
    logic        m_rv;
    bit          m_known = 1'b0;

    always #5 clk = ~clk;

    fetch_unit_if #(.NB_INSTR(32), .NB_PC(32)) bus ();

    fetch_unit dut (
        .clk             (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_step_mode     (step_mode),
        .i_step          (step),
        .i_stall         (stall),
        .i_branch        (branch),
        .i_branch_target (target),
        .bus             (bus),
        .o_halted        (halted),
        .o_idle          (idle)
    );

    // Synchronous 1-cycle instruction memory.
    always @(posedge clk) bus.i_imem_data <= mem[bus.o_imem_addr[9:2]];

    function automatic logic [31:0] fld(int f);
        case (f)
            F_ADDR:  return bus.o_imem_addr;
            F_INSTR: return bus.o_instr;
            F_PC:    return bus.o_pc;
            F_NXT:   return bus.o_pc_next;
            F_V:     return {31'd0, bus.o_valid};
            F_FL:    return {31'd0, bus.o_flush};
            F_H:     return {31'd0, halted};
            default: return {31'd0, idle};
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] e_addr, e_instr, n_pc, n_req, t;
        logic        e_valid, e_flush, n_rv;
        logic [31:0] got_v [8];
        logic [31:0] exp_v [8];
        int          n_mode;
        bit          act;
        pin_t        p;
        act     = (m_mode == M_RUN) || (m_mode == M_STEP);
        e_addr  = m_pc;
        e_valid = 1'b0;
        e_flush = 1'b0;
        n_pc    = m_pc;
        n_req   = m_req;
        n_rv    = m_rv;
        n_mode  = m_mode;
        if (act) begin
            if (branch) begin
                t = target & 32'hFFFF_FFFC;
                e_addr = t; e_flush = 1'b1;
                n_req = t; n_pc = t + 32'd4; n_rv = 1'b1;
            end else if (stall) begin
                e_addr = m_req; e_valid = m_rv;
            end else if (m_rv && mem[m_req[9:2]] == HALT) begin
                n_mode = M_HALT; n_rv = 1'b0;
            end else begin
                e_valid = m_rv; n_req = m_pc;
                if (m_mode == M_RUN || step) begin
                    n_pc = m_pc + 32'd4; n_rv = 1'b1;
                end else begin
                    n_rv = 1'b0;
                end
            end
        end else if (start) begin
            n_mode = step_mode ? M_STEP : M_RUN;
            n_pc = 32'd0; n_req = 32'd0; n_rv = 1'b0;
        end
        e_instr = e_valid ? mem[m_req[9:2]] : NOP;
        if (m_known) begin
            for (int i = 0; i < 8; i++) got_v[i] = fld(i);
            exp_v[F_ADDR]  = e_addr;
            exp_v[F_INSTR] = e_instr;
            exp_v[F_PC]    = m_req;
            exp_v[F_NXT]   = m_req + 32'd4;
            exp_v[F_V]     = {31'd0, e_valid};
            exp_v[F_FL]    = {31'd0, e_flush};
            exp_v[F_H]     = {31'd0, m_mode == M_HALT};
            exp_v[F_I]     = {31'd0, m_mode == M_IDLE};
            tests++;
            if (got_v != exp_v) begin
                fails++;
                $display("FAIL model@%0t got/exp addr=%h/%h instr=%h/%h pc=%h/%h nxt=%h/%h v=%0d/%0d fl=%0d/%0d h=%0d/%0d i=%0d/%0d",
                    $time, got_v[0], exp_v[0], got_v[1], exp_v[1], got_v[2], exp_v[2],
                    got_v[3], exp_v[3], got_v[4], exp_v[4], got_v[5], exp_v[5],
                    got_v[6], exp_v[6], got_v[7], exp_v[7]);
            end
        end
        while (pins.size() > 0) begin
            p = pins.pop_front();
            tests++;
            if (fld(p.fld) !== p.exp) begin
                fails++;
                $display("FAIL %s @%0t: got %h, expected %h", p.name, $time, fld(p.fld), p.exp);
            end
        end
        if (!rst) begin
            m_mode = M_IDLE; m_pc = 32'd0; m_req = 32'd0; m_rv = 1'b0; m_known = 1'b1;
        end else begin
            m_mode = n_mode; m_pc = n_pc; m_req = n_req; m_rv = n_rv;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(string n, int f, logic [31:0] e);
        pins.push_back('{n, f, e});
    endtask

    task automatic pin_reset(string tag);
        pin({tag, "_addr"}, F_ADDR, 32'd0);
        pin({tag, "_instr"}, F_INSTR, NOP);
        pin({tag, "_pc"}, F_PC, 32'd0);
        pin({tag, "_nxt"}, F_NXT, 32'd4);
        pin({tag, "_valid"}, F_V, 32'd0);
        pin({tag, "_flush"}, F_FL, 32'd0);
        pin({tag, "_halted"}, F_H, 32'd0);
        pin({tag, "_idle"}, F_I, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        stall = 1'b0; branch = 1'b0; target = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = i + 1;
        cyc(); cyc();
        pin_reset("por");
        rst = 1'b1;

        // RUN from 0, then stall at 8, then branch to 0x41 under stall
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        pin("t1_c1_valid", F_V, 0); pin("t1_c1_addr", F_ADDR, 0);
        cyc(); pin("t1_c2_valid", F_V, 1); pin("t1_c2_pc", F_PC, 0);
        pin("t1_c2_instr", F_INSTR, 1); pin("t1_c2_nxt", F_NXT, 4);
        cyc(); pin("t1_c3_pc", F_PC, 4); pin("t1_c3_instr", F_INSTR, 2);
        cyc(); stall = 1'b1;
        pin("t2_s0_pc", F_PC, 8); pin("t2_s0_instr", F_INSTR, 3); pin("t2_s0_addr", F_ADDR, 8);
        cyc(); pin("t2_s1_pc", F_PC, 8); pin("t2_s1_instr", F_INSTR, 3);
        cyc(); pin("t2_s2_addr", F_ADDR, 8); pin("t2_s2_valid", F_V, 1);
        cyc(); stall = 1'b0;
        pin("t2_rel_pc", F_PC, 8); pin("t2_rel_addr", F_ADDR, 32'hC);
        cyc(); pin("t2_res_pc", F_PC, 32'hC); pin("t2_res_instr", F_INSTR, 4);
        cyc(); branch = 1'b1; target = 32'h41; stall = 1'b1;
        pin("t3_br_pc", F_PC, 32'h10); pin("t3_br_flush", F_FL, 1);
        pin("t3_br_valid", F_V, 0); pin("t3_br_addr", F_ADDR, 32'h40);
        cyc(); branch = 1'b0; stall = 1'b0;
        pin("t3_tgt_pc", F_PC, 32'h40); pin("t3_tgt_valid", F_V, 1);
        pin("t3_tgt_instr", F_INSTR, 32'h11); pin("t3_tgt_flush", F_FL, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc(); rst = 1'b1;
        pin_reset("rst_run");

        // HALT word at 0xC
        mem[3] = HALT;
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        pin("t4_c4_pc", F_PC, 8);
        cyc(); pin("t4_det_valid", F_V, 0); pin("t4_det_instr", F_INSTR, NOP);
        pin("t4_det_pc", F_PC, 32'hC); pin("t4_det_halted", F_H, 0);
        cyc(); pin("t4_halted", F_H, 1); pin("t4_h_valid", F_V, 0);
        pin("t4_h_instr", F_INSTR, NOP);
        start = 1'b1;
        cyc(); start = 1'b0; pin("t4_rs_halted", F_H, 0);
        cyc(); pin("t4_rs_pc", F_PC, 0); pin("t4_rs_instr", F_INSTR, 1);
        start = 1'b1; step_mode = 1'b1;
        cyc(); start = 1'b0; step_mode = 1'b0;
        pin("t4_ign_pc", F_PC, 4); pin("t4_ign_valid", F_V, 1);
        for (int i = 0; i < 40 && !halted; i++) cyc();
        pin("t4_halt_again", F_H, 1);
        mem[3] = 32'd4;

        // STEP mode, pulses 5 cycles apart
        cyc(); start = 1'b1; step_mode = 1'b1;
        cyc(); start = 1'b0; step_mode = 1'b0;
        pin("t5_valid0", F_V, 0); pin("t5_idle", F_I, 0); pin("t5_halted", F_H, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(); step = 1'b1; pin("t5_pulse_valid", F_V, 0);
            cyc(); step = 1'b0;
            pin("t5_out_valid", F_V, 1); pin("t5_out_pc", F_PC, 4 * k);
            pin("t5_out_instr", F_INSTR, k + 1);
            repeat (3) begin
                cyc(); pin("t5_gap_valid", F_V, 0);
            end
        end
        cyc(); branch = 1'b1; target = 32'h102;
        pin("t5_br_flush", F_FL, 1); pin("t5_br_addr", F_ADDR, 32'h100);
        cyc(); branch = 1'b0;
        pin("t5_br_valid", F_V, 1); pin("t5_br_pc", F_PC, 32'h100);
        pin("t5_br_instr", F_INSTR, 32'h41);
        cyc(); pin("t5_br_after", F_V, 0);

        // reset mid-stall in RUN, then address wrap
        cyc(); rst = 1'b0;
        cyc(); rst = 1'b1;
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc(); stall = 1'b1;
        cyc(); rst = 1'b0;
        cyc(); rst = 1'b1;
        pin_reset("rst_stall");
        cyc(); stall = 1'b0;
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); branch = 1'b1; target = 32'hFFFF_FFFF;
        pin("t6_wrap_addr", F_ADDR, 32'hFFFF_FFFC);
        cyc(); branch = 1'b0;
        pin("t6_wrap_pc", F_PC, 32'hFFFF_FFFC); pin("t6_wrap_nxt", F_NXT, 0);
        pin("t6_wrap_instr", F_INSTR, 32'h100);
        cyc(); pin("t6_after_pc", F_PC, 0); pin("t6_after_instr", F_INSTR, 1);
        pin("t6_after_nxt", F_NXT, 4);
        cyc(); cyc();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
